fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Fetch/execute sequencer for the 16-bit CPU. Requests instructions from instruction memory over a
//  req/ack handshake and loads each returned word into the instruction register via ir_inst/ir_wen.
//  Starts the execute datapath and waits for it to complete, then selects the next PC
//  (sequential or branch). Sits between imem, the instruction register and the execute/control unit.
// PARAMETERS
//  PC_W         16       width of program counter / imem word address
//  RESET_PC     16'h0000 first fetch address after reset
//  TIMEOUT_CYC  15       max wait cycles for imem_ack (used only with FETCH_TIMEOUT_EN)
// PORTS
//  clk          in   1     rising-edge clock
//  resetn       in   1     asynchronous active-low reset
//  imem_req     out  1     fetch request; held until imem_ack
//  imem_addr    out  PC_W  word address of fetch; stable while imem_req=1
//  imem_ack     in   1     imem_rdata valid this cycle; ignored unless imem_req=1
//  imem_rdata   in   16    instruction word
//  ir_inst      out  16    word to instruction register (= imem_rdata)
//  ir_wen       out  1     instruction register write enable, one-cycle pulse
//  pc           out  PC_W  address of instruction currently held in the IR
//  exec_start   out  1     one-cycle pulse: IR contents valid, begin execute
//  exec_done    in   1     execute complete; sampled only in S_EXEC
//  br_taken     in   1     qualifies exec_done: redirect to br_target
//  br_target    in   PC_W  branch destination word address
//  halt         in   1     qualifies exec_done: stop after this instruction
//  busy         out  1     1 in every state except S_IDLE and S_HALT
//  bus_err      out  1     sticky fetch-timeout flag (0 without FETCH_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset (async, resetn=0): state=S_IDLE, fetch_pc=RESET_PC, pc=RESET_PC, bus_err=0.
//    All outputs 0 except imem_addr=pc=RESET_PC.
//  - S_IDLE: one cycle after reset release, then S_FETCH unconditionally.
//  - S_FETCH: imem_req=1, imem_addr=fetch_pc.
//    On imem_ack: ir_wen=1 and ir_inst=imem_rdata combinationally that cycle; pc<=fetch_pc; ->S_DECODE.
//    Without ack: remain in S_FETCH.
//  - S_DECODE: exec_start=1 for exactly one cycle; ->S_EXEC.
//  - S_EXEC: wait for exec_done (exec_done in S_DECODE is ignored). On exec_done:
//    fetch_pc <= br_taken ? br_target : fetch_pc+1 (modulo 2^PC_W, wraps to 0).
//    Next state is S_HALT if halt=1, else S_FETCH. With halt=1, fetch_pc still updates.
//  - S_HALT: all outputs except pc/imem_addr/bus_err are 0. Exit only via reset.
//  - Zero-wait memory throughput is one instruction per 3 cycles (FETCH, DECODE, EXEC).
//  - ir_wen is only ever asserted in S_FETCH with imem_ack=1. ir_inst is don't-care otherwise.
//  - Reset mid-operation: imem_req drops asynchronously. An outstanding fetch is abandoned;
//    imem must tolerate req withdrawal without ack.
// CONFIGURATION
//  FETCH_TIMEOUT_EN defined:
//    - 4-bit+ wait counter clears on entry to S_FETCH and increments each S_FETCH cycle without ack.
//    - When count reaches TIMEOUT_CYC with no ack: bus_err<=1 (sticky until reset), imem_req drops,
//      ->S_HALT.
//    - An ack in the same cycle the counter reaches the limit wins; this is a normal fetch.
//  FETCH_TIMEOUT_EN undefined: no counter; bus_err tied 0; S_FETCH waits indefinitely.
// STRUCTURE
//  - Package cpu_ctrl_pkg: state enum {S_IDLE,S_FETCH,S_DECODE,S_EXEC,S_HALT},
//    INST_W=16, NOP_INST=16'h4300.
//  - Sub-module fetch_watchdog: the timeout counter, instantiated only under FETCH_TIMEOUT_EN.
//  - PC/next-PC logic and the FSM stay in fetch_ctrl.
// TESTING
//  1. Reset, ack returned same cycle as req, rdata 16'h1234, exec_done 1 cycle after exec_start:
//     addrs 0,1,2...; ir_wen/exec_start pulse once per 3 cycles.
//  2. imem_ack delayed 4 cycles: imem_req and imem_addr held stable for 5 cycles;
//     ir_wen asserts exactly once.
//  3. At pc=5, exec_done with br_taken=1, br_target=16'h0040: next imem_addr=16'h0040,
//     and pc=16'h0040 after its ack.
//  4. fetch_pc=16'hFFFF, exec_done with br_taken=0: next imem_addr=16'h0000.
//  5. exec_done with halt=1: ->S_HALT; busy=0; no further imem_req for 20 cycles.
//     Reset restarts at RESET_PC.
//  6. FETCH_TIMEOUT_EN, TIMEOUT_CYC=15, ack never returned: bus_err=1 after 15 cycles, imem_req=0.
//     Repeat with ack on cycle 15: bus_err stays 0.
//     Assert resetn mid-wait: imem_req=0 immediately.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU fetch/execute control slice.
//   state_t  : fetch sequencer states
//   INST_W   : instruction word width
//   NOP_INST : canonical no-op encoding
package cpu_ctrl_pkg;

    localparam int unsigned INST_W = 16;
    localparam logic [INST_W-1:0] NOP_INST = 16'h4300;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus.
//   req   : fetch request, held until ack (master -> slave)
//   addr  : word address, stable while req=1 (master -> slave)
//   ack   : rdata valid this cycle (slave -> master)
//   rdata : instruction word (slave -> master)
interface fetch_ctrl_if
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned PC_W = 16
);
    logic              req;
    logic [PC_W-1:0]   addr;
    logic              ack;
    logic [INST_W-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_watchdog.sv
// Fetch timeout counter.
//   clk, resetn : clock, asynchronous active-low reset
//   active      : sequencer is in the fetch state
//   ack         : memory acknowledge this cycle
//   expire      : this is the TIMEOUT_CYC-th fetch cycle without ack
module fetch_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic resetn,
    input  logic active,
    input  logic ack,
    output logic expire
);
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC + 1) > 4) ? $clog2(TIMEOUT_CYC + 1) : 4;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // Counter sits at zero outside fetch, so it is clear on every entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (!active) begin
            cnt <= '0;
        end else if (!ack) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // cnt holds the number of earlier ack-less cycles; an ack on the last
    // allowed cycle wins over the timeout.
    assign expire = active && !ack && (cnt == LAST);
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch/execute sequencer: fetches a word from imem, loads the IR, starts
// execute, waits for completion and selects the next PC.
//   clk, resetn  : clock, asynchronous active-low reset
//   imem         : instruction memory bus (master side)
//   ir_inst      : word to instruction register, ir_wen : IR write pulse
//   pc           : address of instruction held in the IR
//   exec_start   : one-cycle start pulse to the execute unit
//   exec_done    : execute complete (qualified by br_taken/br_target/halt)
//   busy         : not idle and not halted
//   bus_err      : sticky fetch timeout
// Optional feature: define FETCH_TIMEOUT_EN to enable the fetch watchdog.
module fetch_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned    PC_W        = 16,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int unsigned    TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              resetn,
    fetch_ctrl_if.master      imem,
    output logic [INST_W-1:0] ir_inst,
    output logic              ir_wen,
    output logic [PC_W-1:0]   pc,
    output logic              exec_start,
    input  logic              exec_done,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_target,
    input  logic              halt,
    output logic              busy,
    output logic              bus_err
);
    state_t          state, state_nxt;
    logic [PC_W-1:0] fetch_pc;
    logic            timeout;

`ifdef FETCH_TIMEOUT_EN
    fetch_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .resetn (resetn),
        .active (state == S_FETCH),
        .ack    (imem.ack),
        .expire (timeout)
    );
`else
    assign timeout = 1'b0;
    // TIMEOUT_CYC only has meaning when the watchdog is built in.
    if (TIMEOUT_CYC == 0) begin : g_no_watchdog
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            pc       <= RESET_PC;
            bus_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && imem.ack) begin
                pc <= fetch_pc;
            end
            if (state == S_EXEC && exec_done) begin
                fetch_pc <= br_taken ? br_target : fetch_pc + PC_W'(1);
            end
            if (timeout) begin
                bus_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        imem.req   = 1'b0;
        ir_wen     = 1'b0;
        exec_start = 1'b0;
        busy       = 1'b1;
        unique case (state)
            S_IDLE: begin
                busy      = 1'b0;
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem.req = 1'b1;
                if (imem.ack) begin
                    ir_wen    = 1'b1;
                    state_nxt = S_DECODE;
                end else if (timeout) begin
                    state_nxt = S_HALT;
                end
            end
            S_DECODE: begin
                exec_start = 1'b1;
                state_nxt  = S_EXEC;
            end
            S_EXEC: begin
                if (exec_done) begin
                    state_nxt = halt ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                busy = 1'b0;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign imem.addr = fetch_pc;
    assign ir_inst   = ir_wen ? imem.rdata : '0;
endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
    import cpu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] ir_inst;
    logic        ir_wen;
    logic [15:0] pc;
    logic        exec_start;
    logic        exec_done;
    logic        br_taken;
    logic [15:0] br_target;
    logic        halt;
    logic        busy;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    fetch_ctrl_if #(.PC_W(16)) imem_bus ();

    fetch_ctrl #(
        .PC_W        (16),
        .RESET_PC    (16'h0000),
        .TIMEOUT_CYC (15)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .imem       (imem_bus),
        .ir_inst    (ir_inst),
        .ir_wen     (ir_wen),
        .pc         (pc),
        .exec_start (exec_start),
        .exec_done  (exec_done),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .halt       (halt),
        .busy       (busy),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic [15:0] rdata;
        logic        done;
        logic        br;
        logic [15:0] tgt;
        logic        hlt;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_wen;
        logic [15:0] e_inst;
        logic [15:0] e_pc;
        logic        e_start;
        logic        e_busy;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic ack, input logic [15:0] rdata, input logic done, input logic br,
                       input logic [15:0] tgt, input logic hlt, input logic e_req, input logic [15:0] e_addr,
                       input logic e_wen, input logic [15:0] e_inst, input logic [15:0] e_pc,
                       input logic e_start, input logic e_busy);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.done = done; v.br = br; v.tgt = tgt; v.hlt = hlt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_wen = e_wen; v.e_inst = e_inst;
        v.e_pc = e_pc; v.e_start = e_start; v.e_busy = e_busy;
        vq.push_back(v);
    endtask

    task automatic drive_idle();
        imem_bus.ack   = 1'b0;
        imem_bus.rdata = 16'h0000;
        exec_done      = 1'b0;
        br_taken       = 1'b0;
        br_target      = 16'h0000;
        halt           = 1'b0;
    endtask

    // Assert reset, then release it just after a rising edge.
    task automatic do_reset();
        drive_idle();
        resetn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic timeout_tests();
        int n;
        // No ack at all: 15 request cycles, then halt with bus_err.
        do_reset();
        @(posedge clk); #1;           // IDLE -> FETCH
        n = 0;
        while (imem_bus.req && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        check("to_req_cycles", 0, n, 15);
        check("to_bus_err", 0, bus_err, 1);
        check("to_req_low", 0, imem_bus.req, 0);
        check("to_busy", 0, busy, 0);
        // Ack on the 15th request cycle wins.
        do_reset();
        @(posedge clk); #1;
        for (int i = 1; i < 15; i++) begin
            @(posedge clk); #1;
        end
        imem_bus.ack = 1'b1; imem_bus.rdata = 16'h2222;
        #1;
        check("to15_req", 0, imem_bus.req, 1);
        check("to15_wen", 0, ir_wen, 1);
        @(posedge clk); #1;
        imem_bus.ack = 1'b0;
        check("to15_bus_err", 0, bus_err, 0);
        check("to15_start", 0, exec_start, 1);
        // Reset in the middle of a wait withdraws req at once.
        do_reset();
        repeat (5) @(posedge clk);
        #2;
        check("to_mid_req", 0, imem_bus.req, 1);
        resetn = 1'b0;
        #1;
        check("to_mid_req_rst", 0, imem_bus.req, 0);
        check("to_mid_busy_rst", 0, busy, 0);
    endtask
`endif

    initial begin
        vec_t v;
        drive_idle();
        resetn = 1'b0;
        #12;
        check("rst_req", 0, imem_bus.req, 0);
        check("rst_addr", 0, imem_bus.addr, 16'h0000);
        check("rst_pc", 0, pc, 16'h0000);
        check("rst_wen", 0, ir_wen, 0);
        check("rst_start", 0, exec_start, 0);
        check("rst_busy", 0, busy, 0);
        check("rst_bus_err", 0, bus_err, 0);

        //  ack rdata    done br tgt       hlt  req addr      wen inst     pc        st busy
        add(0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0); // IDLE
        add(1, 16'h1234, 0, 0, 16'h0000, 0,   1, 16'h0000, 1, 16'h1234, 16'h0000, 0, 1); // FETCH 0
        add(0, 16'h0000, 1, 1, 16'h0777, 0,   0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 1); // DECODE, done ignored
        add(0, 16'h0000, 1, 0, 16'h0000, 0,   0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1); // EXEC
        add(1, 16'h1234, 0, 0, 16'h0000, 0,   1, 16'h0001, 1, 16'h1234, 16'h0000, 0, 1);
        add(0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0001, 0, 16'h0000, 16'h0001, 1, 1);
        add(0, 16'h0000, 1, 0, 16'h0000, 0,   0, 16'h0001, 0, 16'h0000, 16'h0001, 0, 1);
        add(1, 16'h1234, 0, 0, 16'h0000, 0,   1, 16'h0002, 1, 16'h1234, 16'h0001, 0, 1);
        add(0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0002, 0, 16'h0000, 16'h0002, 1, 1);
        add(0, 16'h0000, 1, 0, 16'h0000, 0,   0, 16'h0002, 0, 16'h0000, 16'h0002, 0, 1);
        // ack delayed 4 cycles
        add(0, 16'h0000, 0, 0, 16'h0000, 0,   1, 16'h0003, 0, 16'h0000, 16'h0002, 0, 1);
        add(0, 16'h0000, 0, 0, 16'h0000, 0,   1, 16'h0003, 0, 16'h0000, 16'h0002, 0, 1);
        add(0, 16'h0000, 0, 0, 16'h0000, 0,   1, 16'h0003, 0, 16'h0000, 16'h0002, 0, 1);
        add(0, 16'h0000, 0, 0, 16'h0000, 0,   1, 16'h0003, 0, 16'h0000, 16'h0002, 0, 1);
        add(1, 16'hABCD, 0, 0, 16'h0000, 0,   1, 16'h0003, 1, 16'hABCD, 16'h0002, 0, 1);
        add(0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0003, 0, 16'h0000, 16'h0003, 1, 1);
        add(0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0003, 0, 16'h0000, 16'h0003, 0, 1); // EXEC wait
        add(0, 16'h0000, 1, 0, 16'h0000, 0,   0, 16'h0003, 0, 16'h0000, 16'h0003, 0, 1);
        add(1, 16'h1234, 0, 0, 16'h0000, 0,   1, 16'h0004, 1, 16'h1234, 16'h0003, 0, 1);
        add(0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0004, 0, 16'h0000, 16'h0004, 1, 1);
        add(0, 16'h0000, 1, 0, 16'h0000, 0,   0, 16'h0004, 0, 16'h0000, 16'h0004, 0, 1);
        add(1, 16'h1234, 0, 0, 16'h0000, 0,   1, 16'h0005, 1, 16'h1234, 16'h0004, 0, 1);
        add(0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0005, 0, 16'h0000, 16'h0005, 1, 1);
        // branch from pc=5 to 0x0040
        add(0, 16'h0000, 1, 1, 16'h0040, 0,   0, 16'h0005, 0, 16'h0000, 16'h0005, 0, 1);
        add(1, 16'h1234, 0, 0, 16'h0000, 0,   1, 16'h0040, 1, 16'h1234, 16'h0005, 0, 1);
        add(0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0040, 0, 16'h0000, 16'h0040, 1, 1);
        // branch to 0xFFFF, then sequential wrap to 0
        add(0, 16'h0000, 1, 1, 16'hFFFF, 0,   0, 16'h0040, 0, 16'h0000, 16'h0040, 0, 1);
        add(1, 16'h5678, 0, 0, 16'h0000, 0,   1, 16'hFFFF, 1, 16'h5678, 16'h0040, 0, 1);
        add(0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'hFFFF, 0, 16'h0000, 16'hFFFF, 1, 1);
        add(0, 16'h0000, 1, 0, 16'h0000, 0,   0, 16'hFFFF, 0, 16'h0000, 16'hFFFF, 0, 1);
        add(1, 16'h1234, 0, 0, 16'h0000, 0,   1, 16'h0000, 1, 16'h1234, 16'hFFFF, 0, 1);
        add(0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 1);
        // halt: fetch_pc still advances to 1
        add(0, 16'h0000, 1, 0, 16'h0000, 1,   0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1);
        add(0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0001, 0, 16'h0000, 16'h0000, 0, 0); // HALT

        // Release reset just after an edge; each vector: drive, settle, compare, step.
        @(posedge clk);
        #1 resetn = 1'b1;
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            imem_bus.ack   = v.ack;
            imem_bus.rdata = v.rdata;
            exec_done      = v.done;
            br_taken       = v.br;
            br_target      = v.tgt;
            halt           = v.hlt;
            #2;
            check("req", i, imem_bus.req, v.e_req);
            check("addr", i, imem_bus.addr, v.e_addr);
            check("wen", i, ir_wen, v.e_wen);
            if (v.e_wen) check("inst", i, ir_inst, v.e_inst);
            check("pc", i, pc, v.e_pc);
            check("start", i, exec_start, v.e_start);
            check("busy", i, busy, v.e_busy);
            @(posedge clk);
            #1;
        end

        // Halted: no request for 20 cycles, even with ack/exec_done toggling.
        begin
            int req_seen = 0;
            int busy_seen = 0;
            imem_bus.ack = 1'b1;
            exec_done    = 1'b1;
            for (int i = 0; i < 20; i++) begin
                #2;
                if (imem_bus.req) req_seen++;
                if (busy || ir_wen || exec_start) busy_seen++;
                @(posedge clk);
                #1;
            end
            check("halt_req_count", 0, req_seen, 0);
            check("halt_busy_count", 0, busy_seen, 0);
            check("halt_bus_err", 0, bus_err, 0);
        end

        // Reset restarts at RESET_PC.
        do_reset();
        check("rerst_addr", 0, imem_bus.addr, 16'h0000);
        check("rerst_pc", 0, pc, 16'h0000);
        check("rerst_busy", 0, busy, 0);
        @(posedge clk); #1;
        check("rerst_req", 0, imem_bus.req, 1);
        check("rerst_fetch_addr", 0, imem_bus.addr, 16'h0000);

`ifdef FETCH_TIMEOUT_EN
        timeout_tests();
`else
        // Without the watchdog a fetch waits indefinitely.
        repeat (30) @(posedge clk);
        #1;
        check("nowd_req", 0, imem_bus.req, 1);
        check("nowd_bus_err", 0, bus_err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end
endmodule
